// File: rtl/time_display_scan_pkg.sv
// Shared definitions for the time display scanner: scan states, range limits,
// group indices and the time record layout.
`default_nettype none

package time_display_scan_pkg;

  typedef enum logic [1:0] {
    SCAN_H = 2'd0,
    SCAN_M = 2'd1,
    SCAN_S = 2'd2
  } scan_state_t;

  localparam logic [4:0] HOURS_MAX   = 5'd23;
  localparam logic [5:0] MINUTES_MAX = 6'd59;
  localparam logic [5:0] SECONDS_MAX = 6'd59;

  // Bit positions of each group within digit_en.
  localparam int GRP_H = 0;
  localparam int GRP_M = 1;
  localparam int GRP_S = 2;

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } time_t;

  function automatic logic time_in_range(input logic [4:0] h,
                                         input logic [5:0] m,
                                         input logic [5:0] s);
    return (h <= HOURS_MAX) && (m <= MINUTES_MAX) && (s <= SECONDS_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/time_display_scan_pwm_gen.sv
// Dwell counter and H->M->S scan sequencing, plus the guard-cycle / PWM
// comparison that produces the unregistered one-hot group enable.
`default_nettype none

module scan_pwm_gen
  import time_display_scan_pkg::*;
#(
  parameter int DWELL_LOG2 = 8,
  parameter int PWM_BITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PWM_BITS-1:0]   brightness,
  input  logic                  blank,
  output scan_state_t           state,
  output logic [DWELL_LOG2-1:0] dwell_cnt,
  output logic [2:0]            en_raw
);

  scan_state_t           state_next;
  logic [DWELL_LOG2-1:0] dwell_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN_H;
      dwell_cnt <= '0;
    end else begin
      state     <= state_next;
      dwell_cnt <= dwell_next;
    end
  end

  always_comb begin
    state_next = state;
    dwell_next = dwell_cnt + 1'b1;
    en_raw     = '0;

    if (&dwell_cnt) begin
      case (state)
        SCAN_H:  state_next = SCAN_M;
        SCAN_M:  state_next = SCAN_S;
        default: state_next = SCAN_H;
      endcase
    end

    // Count 0 of every dwell is the guard cycle that hides group switching.
    if ((dwell_cnt != '0) && (dwell_cnt[PWM_BITS-1:0] < brightness) && !blank) begin
      case (state)
        SCAN_H:  en_raw[GRP_H] = 1'b1;
        SCAN_M:  en_raw[GRP_M] = 1'b1;
        default: en_raw[GRP_S] = 1'b1;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/time_display_scan.sv
// Captures validated H:M:S strobes into a shadow register, transfers them to
// the displayed copy at frame boundaries, and drives the multiplexed output bus.
`default_nettype none

module time_display_scan
  import time_display_scan_pkg::*;
#(
  parameter int DWELL_LOG2 = 8,
  parameter int PWM_BITS   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                time_valid,
  input  logic [4:0]          hours,
  input  logic [5:0]          minutes,
  input  logic [5:0]          seconds,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                blank,
  output logic [7:0]          seg_data,
  output logic [2:0]          digit_en,
  output logic                frame_start,
  output logic                range_err
);

  scan_state_t           state;
  logic [DWELL_LOG2-1:0] dwell_cnt;
  logic [2:0]            en_raw;

  time_t shadow;
  time_t active;
  logic  pending;

  logic in_range;
  logic capture;
  logic boundary;

  scan_pwm_gen #(
    .DWELL_LOG2(DWELL_LOG2),
    .PWM_BITS  (PWM_BITS)
  ) u_scan_pwm_gen (
    .clk       (clk),
    .rst       (rst),
    .brightness(brightness),
    .blank     (blank),
    .state     (state),
    .dwell_cnt (dwell_cnt),
    .en_raw    (en_raw)
  );

  assign in_range = time_in_range(hours, minutes, seconds);
  assign capture  = time_valid && in_range;
  assign boundary = (state == SCAN_S) && (&dwell_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow      <= '0;
      active      <= '0;
      pending     <= 1'b0;
      seg_data    <= '0;
      digit_en    <= '0;
      frame_start <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      range_err <= time_valid && !in_range;

      if (capture) begin
        shadow <= '{h: hours, m: minutes, s: seconds};
      end

      // A strobe in the boundary cycle stays pending for the following frame.
      if (boundary && pending) begin
        active <= shadow;
      end

      if (capture) begin
        pending <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end

      case (state)
        SCAN_H:  seg_data <= {3'b000, active.h};
        SCAN_M:  seg_data <= {2'b00, active.m};
        default: seg_data <= {2'b00, active.s};
      endcase

      digit_en    <= en_raw;
      frame_start <= (state == SCAN_H) && (dwell_cnt == '0);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_time_display_scan.sv
// Directed bench with a frame-indexed scoreboard of displayed time values and
// a cycle-position model for digit_en, frame_start, seg_data and range_err.
module tb_time_display_scan;

  localparam int DWELL = 256;
  localparam int FRAME = 3 * DWELL;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       time_valid = 1'b0;
  logic [4:0] hours = '0;
  logic [5:0] minutes = '0;
  logic [5:0] seconds = '0;
  logic [3:0] brightness = 4'hF;
  logic       blank = 1'b0;
  logic [7:0] seg_data;
  logic [2:0] digit_en;
  logic       frame_start;
  logic       range_err;

  time_display_scan #(
    .DWELL_LOG2(8),
    .PWM_BITS  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .time_valid (time_valid),
    .hours      (hours),
    .minutes    (minutes),
    .seconds    (seconds),
    .brightness (brightness),
    .blank      (blank),
    .seg_data   (seg_data),
    .digit_en   (digit_en),
    .frame_start(frame_start),
    .range_err  (range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          frame;
    logic [16:0] val;
  } sb_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [16:0] disp = '0;
  sb_t         q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: snapshot inputs, step, then compare every output against the model.
  task automatic tick();
    int          pos, frame, dw, grp;
    logic        tv, ok, bl;
    logic [3:0]  b;
    logic [16:0] v;
    logic [2:0]  en_e;
    logic [7:0]  seg_e;
    sb_t         e;
    pos   = cyc % FRAME;
    frame = cyc / FRAME;
    tv    = time_valid;
    ok    = (hours <= 5'd23) && (minutes <= 6'd59) && (seconds <= 6'd59);
    v     = {hours, minutes, seconds};
    b     = brightness;
    bl    = blank;
    @(posedge clk);
    #1;
    cyc++;
    if (tv && ok) begin
      e.frame = frame + ((pos == FRAME - 1) ? 2 : 1);
      e.val   = v;
      q.push_back(e);
    end
    if (pos == 0) begin
      while (q.size() > 0 && q[0].frame <= frame) begin
        e    = q.pop_front();
        disp = e.val;
      end
    end
    dw  = pos % DWELL;
    grp = pos / DWELL;
    en_e = ((dw != 0) && ((dw % 16) < int'(b)) && !bl) ? (3'b001 << grp) : 3'b000;
    case (grp)
      0:       seg_e = {3'b000, disp[16:12]};
      1:       seg_e = {2'b00, disp[11:6]};
      default: seg_e = {2'b00, disp[5:0]};
    endcase
    chk("frame_start", {31'd0, frame_start}, {31'd0, (pos == 0)});
    chk("digit_en", {29'd0, digit_en}, {29'd0, en_e});
    chk("seg_data", {24'd0, seg_data}, {24'd0, seg_e});
    chk("range_err", {31'd0, range_err}, {31'd0, (tv && !ok)});
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Advance until the next tick samples position p of the frame.
  task automatic run_to(input int p);
    while ((cyc % FRAME) != p) tick();
  endtask

  task automatic strobe(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    time_valid = 1'b1;
    hours      = h;
    minutes    = m;
    seconds    = s;
    tick();
    time_valid = 1'b0;
  endtask

  task automatic dwell_count(input logic [3:0] b);
    int cnt;
    int exp;
    run_to(0);
    brightness = b;
    cnt = 0;
    repeat (DWELL) begin
      tick();
      if (digit_en != 3'b000) cnt++;
    end
    exp = 16 * int'(b) - ((b != 4'd0) ? 1 : 0);
    chk("dwell_on_count", cnt, exp);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", {24'd0, seg_data}, 32'd0);
    chk("rst_en", {29'd0, digit_en}, 32'd0);
    chk("rst_fs", {31'd0, frame_start}, 32'd0);
    chk("rst_err", {31'd0, range_err}, 32'd0);
    rst = 1'b0;

    // Free-running scan, nothing displayed yet
    run(2 * FRAME);

    // Strobe mid-M; shown in the following frame
    run_to(300);
    strobe(5'd13, 6'd45, 6'd7);
    run_to(0);
    tick();
    chk("show_h", {24'd0, seg_data}, 32'h0D);
    run_to(DWELL);
    tick();
    chk("show_m", {24'd0, seg_data}, 32'h2D);
    run_to(2 * DWELL);
    tick();
    chk("show_s", {24'd0, seg_data}, 32'h07);

    // Out-of-range strobes leave the pending value intact
    run_to(100);
    strobe(5'd2, 6'd3, 6'd4);
    run_to(200);
    strobe(5'd24, 6'd0, 6'd0);
    run(5);
    strobe(5'd1, 6'd60, 6'd0);
    run(5);
    strobe(5'd1, 6'd0, 6'd60);
    run_to(0);
    run(FRAME);

    // Two strobes in one frame, then one on the boundary cycle
    run_to(50);
    strobe(5'd1, 6'd2, 6'd3);
    run_to(400);
    strobe(5'd4, 6'd5, 6'd6);
    run_to(FRAME - 1);
    strobe(5'd9, 6'd10, 6'd11);
    tick();
    chk("last_wins_h", {24'd0, seg_data}, 32'h04);
    run_to(0);
    tick();
    chk("boundary_h", {24'd0, seg_data}, 32'h09);
    run(FRAME);

    // Brightness duty and blanking
    dwell_count(4'd0);
    dwell_count(4'd1);
    dwell_count(4'd8);
    dwell_count(4'd15);
    run_to(500);
    blank = 1'b1;
    run(FRAME);
    blank = 1'b0;
    run(100);

    // Asynchronous reset mid-S with 23:59:59 displayed
    run_to(10);
    strobe(5'd23, 6'd59, 6'd59);
    run_to(0);
    run_to(600);
    chk("pre_rst_s", {24'd0, seg_data}, 32'h3B);
    #2;
    rst = 1'b1;
    #1;
    chk("async_seg", {24'd0, seg_data}, 32'd0);
    chk("async_en", {29'd0, digit_en}, 32'd0);
    chk("async_fs", {31'd0, frame_start}, 32'd0);
    chk("async_err", {31'd0, range_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("held_seg", {24'd0, seg_data}, 32'd0);
    rst  = 1'b0;
    cyc  = 0;
    disp = '0;
    q.delete();
    run(FRAME + 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
